// File: rtl/ram_bist_seq_36.sv
// BIST sequencer for a 1K x 36 RAM port with byte enables and a registered output stage.
// Runs one write pass and one read-compare pass, then reports pass/fail, error count and first failing address.
module ram_bist_seq_36 #(
    parameter int LAST_ADDR = 1023,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  seed,
    output logic [9:0]  ram_addr,
    output logic [35:0] ram_din,
    output logic        ram_we,
    output logic [1:0]  ram_be,
    output logic        ram_out_enable,
    input  logic [35:0] ram_dout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_cnt,
    output logic [9:0]  fail_addr
);

    localparam logic [9:0]    LAST       = 10'(LAST_ADDR);
    localparam int            DW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);
    localparam logic [10:0]   ERR_MAX    = 11'h7FF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [35:0] pat(input logic [9:0] a, input logic [5:0] s);
        return {a, ~a, a, s};
    endfunction

    state_t         state_q, state_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic [5:0]     seed_q, seed_d;
    logic [9:0]     addr_d;
    logic [35:0]    din_d;
    logic           we_d, oe_d, busy_d, done_d, pass_d;
    logic [1:0]     be_d;
    logic [10:0]    err_d;
    logic [9:0]     fail_d;
    logic           mismatch;

    // Read-address pipeline, aligned so the last stage meets the matching ram_dout.
    logic [RD_LAT-1:0] pipe_v;
    logic [9:0]        pipe_a [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= (state_q == READ);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_a[0] <= ram_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign mismatch = pipe_v[RD_LAT-1] && (ram_dout != pat(pipe_a[RD_LAT-1], seed_q));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        seed_d  = seed_q;
        addr_d  = ram_addr;
        din_d   = '0;
        we_d    = 1'b0;
        be_d    = 2'b00;
        oe_d    = 1'b0;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_cnt;
        fail_d  = fail_addr;

        if (mismatch) begin
            if (err_cnt != ERR_MAX) begin
                err_d = err_cnt + 11'd1;
            end
            if (err_cnt == 11'd0) begin
                fail_d = pipe_a[RD_LAT-1];
            end
        end

        case (state_q)
            IDLE, DONE: begin
                addr_d = '0;
                if (start) begin
                    state_d = WRITE;
                    seed_d  = seed;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    be_d    = 2'b11;
                    din_d   = pat(10'd0, seed);
                end
            end
            WRITE: begin
                if (ram_addr == LAST) begin
                    // Read of address 0 follows the last write with no gap.
                    state_d = READ;
                    addr_d  = '0;
                    oe_d    = 1'b1;
                end else begin
                    addr_d = ram_addr + 10'd1;
                    we_d   = 1'b1;
                    be_d   = 2'b11;
                    din_d  = pat(ram_addr + 10'd1, seed_q);
                end
            end
            READ: begin
                oe_d = 1'b1;
                if (ram_addr == LAST) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                    drain_d = '0;
                end else begin
                    addr_d = ram_addr + 10'd1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    // err_d already includes the final compare of this cycle.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 11'd0);
                end else begin
                    drain_d = drain_q + DW'(1);
                    oe_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            drain_q        <= '0;
            seed_q         <= '0;
            ram_addr       <= '0;
            ram_din        <= '0;
            ram_we         <= 1'b0;
            ram_be         <= 2'b00;
            ram_out_enable <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            fail_addr      <= '0;
        end else begin
            state_q        <= state_d;
            drain_q        <= drain_d;
            seed_q         <= seed_d;
            ram_addr       <= addr_d;
            ram_din        <= din_d;
            ram_we         <= we_d;
            ram_be         <= be_d;
            ram_out_enable <= oe_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_cnt        <= err_d;
            fail_addr      <= fail_d;
        end
    end

endmodule

// File: tb/tb_ram_bist_seq_36.sv
// Bench for ram_bist_seq_36: behavioural RAM with injectable read faults, expected-result queue,
// and a monitor that checks the write stream and each completed test.
module tb_ram_bist_seq_36;

    localparam int LAST_ADDR = 1023;
    localparam int RD_LAT    = 2;
    localparam int RUN_CYC   = 2 * (LAST_ADDR + 1) + RD_LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  seed;
    logic [9:0]  ram_addr;
    logic [35:0] ram_din;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic        ram_out_enable;
    logic [35:0] ram_dout;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_cnt;
    logic [9:0]  fail_addr;

    always #5 clk = ~clk;

    ram_bist_seq_36 #(.LAST_ADDR(LAST_ADDR), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_be(ram_be),
        .ram_out_enable(ram_out_enable), .ram_dout(ram_dout),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr)
    );

    // RAM model: byte lane 0 = bits 17:0, lane 1 = bits 35:18; faults act on the read path.
    logic [35:0] mem    [1024];
    logic [35:0] stuck1 [1024];
    logic [35:0] flip   [1024];
    logic [35:0] rd_q;

    always @(posedge clk) begin
        if (ram_we) begin
            if (ram_be[0]) mem[ram_addr][17:0]  <= ram_din[17:0];
            if (ram_be[1]) mem[ram_addr][35:18] <= ram_din[35:18];
        end
        rd_q <= (mem[ram_addr] | stuck1[ram_addr]) ^ flip[ram_addr];
        if (ram_out_enable) ram_dout <= rd_q;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] pat(input logic [9:0] a, input logic [5:0] s);
        return {a, ~a, a, s};
    endfunction

    // Expected entry: {seed[5:0], pass, err_cnt[10:0], fail_addr[9:0]}
    logic [27:0] exp_q [$];

    function automatic logic [27:0] model(input logic [5:0] s);
        int n = 0;
        logic [9:0] first = '0;
        for (int a = 0; a <= LAST_ADDR; a++) begin
            logic [35:0] good, seen;
            good = pat(10'(a), s);
            seen = (good | stuck1[a]) ^ flip[a];
            if (seen != good) begin
                if (n == 0) first = 10'(a);
                if (n < 2047) n++;
            end
        end
        return {s, (n == 0), 11'(n), first};
    endfunction

    logic        busy_p = 1'b0;
    logic        done_p = 1'b0;
    int          t_busy = 0;
    int          wr_cnt = 0;
    int          wr_bad = 0;
    logic [9:0]  wr_nxt = '0;
    logic [5:0]  mon_seed;
    logic [27:0] e;

    always @(negedge clk) begin
        if (busy && !busy_p) t_busy = cyc;
        mon_seed = (exp_q.size() > 0) ? exp_q[0][27:22] : 6'd0;
        if (ram_we) begin
            if (ram_addr == 10'd0) begin
                wr_cnt = 0;
                wr_bad = 0;
                wr_nxt = '0;
            end
            if (ram_addr !== wr_nxt || ram_be !== 2'b11 || ram_din !== pat(ram_addr, mon_seed)) wr_bad++;
            wr_cnt++;
            wr_nxt = ram_addr + 10'd1;
        end else if (ram_din !== 36'd0 || ram_be !== 2'b00) begin
            wr_bad++;
        end
        if (done && !done_p) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                e = exp_q.pop_front();
                chk("pass", 64'(pass), 64'(e[21]));
                chk("err_cnt", 64'(err_cnt), 64'(e[20:10]));
                chk("fail_addr", 64'(fail_addr), 64'(e[9:0]));
                chk("latency", 64'(cyc - t_busy), 64'(RUN_CYC));
                chk("write_count", 64'(wr_cnt), 64'(LAST_ADDR + 1));
                chk("write_stream", 64'(wr_bad), 64'd0);
                chk("done_ram_outputs", 64'({ram_we, ram_out_enable, ram_be, ram_addr, busy}), 64'd0);
            end
        end
        busy_p = busy;
        done_p = done;
    end

    task automatic clear_faults();
        for (int a = 0; a < 1024; a++) begin
            stuck1[a] = '0;
            flip[a]   = '0;
        end
    endtask

    task automatic add_random_faults(input int n);
        for (int i = 0; i < n; i++) begin
            flip[$urandom_range(0, LAST_ADDR)] = 36'($urandom_range(1, 65535)) << $urandom_range(0, 20);
        end
    endtask

    task automatic issue(input logic [5:0] s);
        exp_q.push_back(model(s));
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed  = 6'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < RUN_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d cycles expected done", n);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] s;
        rst   = 1'b1;
        start = 1'b0;
        seed  = '0;
        clear_faults();
        repeat (3) @(negedge clk);
        chk("reset_ram", 64'({ram_addr, ram_din, ram_we, ram_be, ram_out_enable}), 64'd0);
        chk("reset_status", 64'({busy, done, pass, err_cnt, fail_addr}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean RAM.
        issue(6'h2A);
        wait_done();

        // Bit 0 stuck-at-1 at address 5.
        stuck1[5] = 36'h1;
        issue(6'h00);
        wait_done();
        clear_faults();

        // Two corruptions; first failing address is the lower one.
        flip[700] = 36'($urandom_range(1, 65535));
        flip[3]   = 36'($urandom_range(1, 65535)) << 20;
        issue(6'($urandom));
        wait_done();
        clear_faults();

        // Extra starts mid-run are ignored.
        s = 6'($urandom);
        issue(s);
        repeat (9) @(negedge clk);
        seed = ~s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1489) @(negedge clk);
        seed = ~s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset during write of address 500, then start coinciding with reset.
        issue(6'($urandom));
        repeat (500) @(negedge clk);
        chk("addr_before_reset", 64'(ram_addr), 64'd500);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("reset_mid_we", 64'(ram_we), 64'd0);
        chk("reset_mid_status", 64'({busy, done, err_cnt}), 64'd0);
        chk("reset_mid_ram", 64'({ram_addr, ram_din, ram_be, ram_out_enable}), 64'd0);
        start = 1'b1;
        @(negedge clk);
        chk("rst_wins_over_start", 64'({busy, ram_we}), 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        issue(6'($urandom));
        wait_done();

        // Failing run, then back-to-back start from DONE with seed 6'h15.
        add_random_faults(3);
        issue(6'($urandom));
        wait_done();
        clear_faults();
        issue(6'h15);
        chk("restart_clears", 64'({done, pass, err_cnt, busy}), 64'd1);
        wait_done();

        // Randomized runs.
        for (int r = 0; r < 3; r++) begin
            add_random_faults($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) stuck1[$urandom_range(0, LAST_ADDR)] = 36'h1 << $urandom_range(0, 35);
            issue(6'($urandom));
            wait_done();
            clear_faults();
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
